fp_mul_pipe: RTL and testbench
==============================

// Module: fp_mul_pipe
// PURPOSE
//  Pipelined IEEE-754 binary32/binary64 multiplier with valid/ready handshake on both sides.
//  Adds correct rounding (RNE/RTZ), overflow/underflow saturation, exception flags and backpressure.
//  Sits in the FPU datapath beside the adder; issues one op per cycle; fixed 3-cycle latency when not stalled.
// PARAMETERS
//  X        32  operand/result width; only 32 (E=8,M=23) or 64 (E=11,M=52) are legal
//  EW       derived (localparam): exponent bits = (X==32)?8:11
//  MW       derived (localparam): fraction bits = (X==32)?23:52
// PORTS
//  clk        in   1    rising-edge clock
//  rst_n      in   1    asynchronous, active-low reset
//  in_valid   in   1    operand beat valid
//  in_ready   out  1    block can accept a beat this cycle
//  a, b       in   X    IEEE operands
//  rnd_mode   in   1    0 = round-nearest-even, 1 = round-toward-zero; sampled with operands
//  out_valid  out  1    result beat valid
//  out_ready  in   1    consumer accepts result
//  result     out  X    IEEE product
//  flags      out  4    {invalid, overflow, underflow, inexact}, aligned with result
// BEHAVIOUR
//  Reset: all stage valids=0, out_valid=0, result=0, flags=0; in_ready=1 one cycle after release.
//  Handshake: transfer on valid&ready. Stage k loads when its register is empty, or when it
//   advances this cycle. in_ready = !s1_v | s1_adv. out_valid/result/flags come straight from
//   S3 registers. A held out_valid keeps result/flags stable until accepted. Order is preserved.
//   Capacity is 3 beats, with no drop and no duplicate.
//  S1 (unpack): sign=a[X-1]^b[X-1]. Classify zero/inf/NaN/normal. Subnormal inputs are
//   treated as signed zero (DAZ). Special result and flag are resolved here:
//   0*inf or NaN operand -> canonical qNaN {0,1s,1,0s}. Invalid=1 for 0*inf or any sNaN.
//   inf*x -> signed inf. 0*x -> signed zero. No inexact on any special.
//   exp_sum = ea+eb-bias, signed EW+2 bits.
//  S2 (multiply): prod = {1,ma}*{1,mb}, width 2*MW+2. The special-case bypass is carried alongside.
//  S3 (normalize/round/pack):
//   If prod MSB=1: shift right 1, exp+1.
//   Keep MW fraction bits plus guard; sticky = OR of the rest.
//   RNE increments when guard&(sticky|lsb). RTZ truncates. A mantissa carry-out renormalises, exp+1.
//   Inexact = guard|sticky.
//   Overflow (biased exp >= 2^EW-1): RNE -> signed inf, RTZ -> signed max-finite. Overflow=1, inexact=1.
//   Underflow (biased exp <= 0 after rounding): flush to signed zero (FTZ). Underflow=1, inexact=1.
//  Simultaneous accept-in and emit-out in the same cycle is legal, with full throughput.
//  rst_n asserted mid-operation: all in-flight beats are discarded and out_valid drops
//   asynchronously; no stale beat appears after release.
//  No combinational path from in_valid to out_valid. Only out_ready->in_ready is combinational.
// STRUCTURE
//  fp_mul_pkg: EW/MW functions of X, bias, canonical qNaN, rnd_mode encodings, flag bit indices.
//  Sub-module fp_mul_round (combinational S3 logic: normalize, round, overflow/underflow, pack),
//   instantiated once. S1/S2 stay inline.
//  The multiply is written as '*' for synthesis retiming.
// TESTING  (X=32 unless noted; latency counted from accept to out_valid)
//  1. a=0x40400000 (3.0), b=0x40200000 (2.5), RNE, out_ready=1
//     -> result 0x40F00000, flags 0000, out_valid exactly 3 cycles later.
//  2. a=0x00000000, b=0x7F800000 -> result 0x7FC00000, flags 1000.
//     a=0xFF800000, b=0x40000000 -> result 0xFF800000, flags 0000.
//  3. a=0x7F000000, b=0x40000000: RNE -> 0x7F800000 flags 0101; RTZ -> 0x7F7FFFFF flags 0101.
//  4. a=b=0x3F800001: RNE -> 0x3F800002 inexact=1.
//     a=0x00800000, b=0x3F000000 -> 0x00000000, flags 0011.
//  5. Backpressure: 6 back-to-back beats, out_ready=0 for 8 cycles.
//     -> in_ready falls after the 3rd beat; all 6 results emerge in order once released.
//     Scoreboard vs a C reference model.
//  6. rst_n pulsed low with 2 beats in flight -> out_valid=0 at once; no output after release.
//     Rerun test 1 with X=64: 3.0*2.5 -> 0x401E000000000000.

Source files
------------

// File: rtl/fp_mul_pkg.sv
// rtl/fp_mul_pkg.sv - widths, encodings and classification helpers for the FP multiplier
package fp_mul_pkg;

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_NORM,
    CLS_INF,
    CLS_NAN
  } fp_class_e;

  localparam logic RND_RNE = 1'b0;
  localparam logic RND_RTZ = 1'b1;

  localparam int FLAG_NX = 0;
  localparam int FLAG_UF = 1;
  localparam int FLAG_OF = 2;
  localparam int FLAG_NV = 3;

  function automatic int ew_of(input int x);
    return (x == 64) ? 11 : 8;
  endfunction

  function automatic int mw_of(input int x);
    return (x == 64) ? 52 : 23;
  endfunction

  function automatic int bias_of(input int x);
    return (1 << (ew_of(x) - 1)) - 1;
  endfunction

  function automatic logic [63:0] qnan_of(input int x);
    return (x == 64) ? 64'h7FF8_0000_0000_0000 : 64'h0000_0000_7FC0_0000;
  endfunction

  // Subnormals fall into CLS_ZERO: inputs are flushed (DAZ).
  function automatic fp_class_e classify(input logic exp_zero, input logic exp_ones,
                                         input logic frac_zero);
    if (exp_zero) return CLS_ZERO;
    if (!exp_ones) return CLS_NORM;
    return frac_zero ? CLS_INF : CLS_NAN;
  endfunction

endpackage

// File: rtl/fp_mul_pipe_if.sv
// rtl/fp_mul_pipe_if.sv - operand/result handshake bundle for the FP multiplier
interface fp_mul_pipe_if #(
  parameter int X = 32
) ();
  logic         in_valid;
  logic         in_ready;
  logic [X-1:0] a;
  logic [X-1:0] b;
  logic         rnd_mode;
  logic         out_valid;
  logic         out_ready;
  logic [X-1:0] result;
  logic [3:0]   flags;

  modport master (
    output in_valid, a, b, rnd_mode, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, a, b, rnd_mode, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/fp_mul_round.sv
// rtl/fp_mul_round.sv - normalize, round, saturate/flush and pack a raw significand product
module fp_mul_round
  import fp_mul_pkg::*;
#(
  parameter int X = 32
) (
  input  logic                       sign_i,
  input  logic                       rnd_i,
  input  logic signed [ew_of(X)+1:0] exp_i,
  input  logic [2*mw_of(X)+1:0]      prod_i,
  output logic [X-1:0]               res_o,
  output logic [3:0]                 flags_o
);
  localparam int EW = ew_of(X);
  localparam int MW = mw_of(X);
  localparam int PW = 2 * MW + 2;
  localparam logic signed [EW+1:0] EXP_SAT = (EW+2)'((1 << EW) - 1);
  localparam logic signed [EW+1:0] EXP_ONE = (EW+2)'(1);

  logic                 msb;
  logic [MW-1:0]        frac;
  logic                 guard, sticky, inexact, inc, carry;
  logic [MW:0]          frac_r;
  logic signed [EW+1:0] exp_n, exp_r;

  always_comb begin
    msb     = prod_i[PW-1];
    frac    = msb ? prod_i[PW-2:MW+1] : prod_i[PW-3:MW];
    guard   = msb ? prod_i[MW] : prod_i[MW-1];
    sticky  = msb ? (|prod_i[MW-1:0]) : (|prod_i[MW-2:0]);
    exp_n   = exp_i + {{(EW+1){1'b0}}, msb};
    inexact = guard | sticky;
    inc     = (rnd_i == RND_RNE) & guard & (sticky | frac[0]);
    frac_r  = {1'b0, frac} + {{MW{1'b0}}, inc};
    // A carry out leaves frac_r[MW-1:0] all zero, which is already the renormalised fraction.
    carry   = frac_r[MW];
    exp_r   = exp_n + {{(EW+1){1'b0}}, carry};
    flags_o = '0;
    if (exp_r >= EXP_SAT) begin
      res_o = (rnd_i == RND_RTZ) ? {sign_i, {(EW-1){1'b1}}, 1'b0, {MW{1'b1}}}
                                 : {sign_i, {EW{1'b1}}, {MW{1'b0}}};
      flags_o[FLAG_OF] = 1'b1;
      flags_o[FLAG_NX] = 1'b1;
    end else if (exp_r < EXP_ONE) begin
      res_o = {sign_i, {(X-1){1'b0}}};
      flags_o[FLAG_UF] = 1'b1;
      flags_o[FLAG_NX] = 1'b1;
    end else begin
      res_o = {sign_i, exp_r[EW-1:0], frac_r[MW-1:0]};
      flags_o[FLAG_NX] = inexact;
    end
  end
endmodule

// File: rtl/fp_mul_pipe.sv
// rtl/fp_mul_pipe.sv - 3-stage IEEE-754 multiplier: unpack, multiply, round/pack
// Each stage loads when empty or draining; only out_ready reaches in_ready combinationally.
module fp_mul_pipe
  import fp_mul_pkg::*;
#(
  parameter int X = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  fp_mul_pipe_if.slave io
);
  localparam int EW = ew_of(X);
  localparam int MW = mw_of(X);
  localparam int PW = 2 * MW + 2;
  localparam logic [EW+1:0] BIAS = (EW+2)'(bias_of(X));
  localparam logic [63:0]   QNAN_W = qnan_of(X);
  localparam logic [X-1:0]  QNAN = QNAN_W[X-1:0];

  logic                 rdy_q;
  logic                 s1_v_q, s2_v_q, s3_v_q;
  logic                 s1_en, s2_en, s3_en;

  logic                 s1_sign_q, s1_rnd_q, s1_spec_q;
  logic signed [EW+1:0] s1_exp_q;
  logic [MW-1:0]        s1_ma_q, s1_mb_q;
  logic [X-1:0]         s1_sres_q;
  logic [3:0]           s1_sflg_q;

  logic                 s2_sign_q, s2_rnd_q, s2_spec_q;
  logic signed [EW+1:0] s2_exp_q;
  logic [PW-1:0]        s2_prod_q;
  logic [X-1:0]         s2_sres_q;
  logic [3:0]           s2_sflg_q;

  logic [X-1:0]         s3_res_q;
  logic [3:0]           s3_flg_q;

  logic [EW-1:0]        ea, eb;
  logic [MW-1:0]        ma, mb;
  fp_class_e            ca, cb;
  logic                 any_nan, zero_inf, snan;
  logic                 s1_sign_d, s1_spec_d;
  logic signed [EW+1:0] s1_exp_d;
  logic [X-1:0]         s1_sres_d;
  logic [3:0]           s1_sflg_d;
  logic [PW-1:0]        s2_prod_d;
  logic [X-1:0]         rnd_res, s3_res_d;
  logic [3:0]           rnd_flg, s3_flg_d;

  assign s3_en       = !s3_v_q | io.out_ready;
  assign s2_en       = !s2_v_q | s3_en;
  assign s1_en       = !s1_v_q | s2_en;
  assign io.in_ready = rdy_q & s1_en;

  always_comb begin
    ea        = io.a[X-2:MW];
    eb        = io.b[X-2:MW];
    ma        = io.a[MW-1:0];
    mb        = io.b[MW-1:0];
    ca        = classify(ea == '0, &ea, ma == '0);
    cb        = classify(eb == '0, &eb, mb == '0);
    s1_sign_d = io.a[X-1] ^ io.b[X-1];
    any_nan   = (ca == CLS_NAN) || (cb == CLS_NAN);
    zero_inf  = ((ca == CLS_ZERO) && (cb == CLS_INF)) || ((ca == CLS_INF) && (cb == CLS_ZERO));
    snan      = ((ca == CLS_NAN) && !ma[MW-1]) || ((cb == CLS_NAN) && !mb[MW-1]);
    s1_sflg_d = '0;
    s1_sflg_d[FLAG_NV] = zero_inf | snan;
    s1_spec_d = 1'b1;
    if (any_nan || zero_inf) begin
      s1_sres_d = QNAN;
    end else if ((ca == CLS_INF) || (cb == CLS_INF)) begin
      s1_sres_d = {s1_sign_d, {EW{1'b1}}, {MW{1'b0}}};
    end else if ((ca == CLS_ZERO) || (cb == CLS_ZERO)) begin
      s1_sres_d = {s1_sign_d, {(X-1){1'b0}}};
    end else begin
      s1_spec_d = 1'b0;
      s1_sres_d = '0;
    end
    s1_exp_d = {2'b00, ea} + {2'b00, eb} - BIAS;
  end

  assign s2_prod_d = PW'({1'b1, s1_ma_q}) * PW'({1'b1, s1_mb_q});

  fp_mul_round #(.X(X)) u_round (
    .sign_i  (s2_sign_q),
    .rnd_i   (s2_rnd_q),
    .exp_i   (s2_exp_q),
    .prod_i  (s2_prod_q),
    .res_o   (rnd_res),
    .flags_o (rnd_flg)
  );

  assign s3_res_d = s2_spec_q ? s2_sres_q : rnd_res;
  assign s3_flg_d = s2_spec_q ? s2_sflg_q : rnd_flg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q     <= 1'b0;
      s1_v_q    <= 1'b0;
      s2_v_q    <= 1'b0;
      s3_v_q    <= 1'b0;
      s1_sign_q <= 1'b0;
      s1_rnd_q  <= 1'b0;
      s1_spec_q <= 1'b0;
      s1_exp_q  <= '0;
      s1_ma_q   <= '0;
      s1_mb_q   <= '0;
      s1_sres_q <= '0;
      s1_sflg_q <= '0;
      s2_sign_q <= 1'b0;
      s2_rnd_q  <= 1'b0;
      s2_spec_q <= 1'b0;
      s2_exp_q  <= '0;
      s2_prod_q <= '0;
      s2_sres_q <= '0;
      s2_sflg_q <= '0;
      s3_res_q  <= '0;
      s3_flg_q  <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (s1_en) begin
        s1_v_q <= io.in_valid & io.in_ready;
        if (io.in_valid & io.in_ready) begin
          s1_sign_q <= s1_sign_d;
          s1_rnd_q  <= io.rnd_mode;
          s1_spec_q <= s1_spec_d;
          s1_exp_q  <= s1_exp_d;
          s1_ma_q   <= ma;
          s1_mb_q   <= mb;
          s1_sres_q <= s1_sres_d;
          s1_sflg_q <= s1_sflg_d;
        end
      end
      if (s2_en) begin
        s2_v_q <= s1_v_q;
        if (s1_v_q) begin
          s2_sign_q <= s1_sign_q;
          s2_rnd_q  <= s1_rnd_q;
          s2_spec_q <= s1_spec_q;
          s2_exp_q  <= s1_exp_q;
          s2_prod_q <= s2_prod_d;
          s2_sres_q <= s1_sres_q;
          s2_sflg_q <= s1_sflg_q;
        end
      end
      if (s3_en) begin
        s3_v_q <= s2_v_q;
        if (s2_v_q) begin
          s3_res_q <= s3_res_d;
          s3_flg_q <= s3_flg_d;
        end
      end
    end
  end

  assign io.out_valid = s3_v_q;
  assign io.result    = s3_res_q;
  assign io.flags     = s3_flg_q;
endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb/tb_fp_mul_pipe.sv - directed and randomized checks of fp_mul_pipe against an arithmetic model
module tb_fp_mul_pipe;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   lat;
  int   seen;

  fp_mul_pipe_if #(.X(32)) io ();
  fp_mul_pipe_if #(.X(64)) io64 ();

  fp_mul_pipe #(.X(32)) dut (.clk(clk), .rst_n(rst_n), .io(io));
  fp_mul_pipe #(.X(64)) dut64 (.clk(clk), .rst_n(rst_n), .io(io64));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // Exact integer product, scaled by a searched shift and rounded by comparing the remainder to half.
  function automatic logic [35:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic rm);
    int ea, eb, e, sh;
    logic s, za, zb, ia, ib, na, nb;
    longint p, q, rem, half;
    logic [3:0] f;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    za = (ea == 0);
    zb = (eb == 0);
    ia = (ea == 255) && (a[22:0] == 0);
    ib = (eb == 255) && (b[22:0] == 0);
    na = (ea == 255) && (a[22:0] != 0);
    nb = (eb == 255) && (b[22:0] != 0);
    if (na || nb || (za && ib) || (ia && zb)) begin
      f = '0;
      f[3] = (za && ib) || (ia && zb) || (na && !a[22]) || (nb && !b[22]);
      return {f, 32'h7FC0_0000};
    end
    if (ia || ib) return {4'b0000, s, 8'hFF, 23'h0};
    if (za || zb) return {4'b0000, s, 31'h0};
    p  = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
    sh = 0;
    while ((p >> sh) >= (longint'(1) << 24)) sh++;
    q    = p >> sh;
    rem  = p - (q << sh);
    half = longint'(1) << (sh - 1);
    e    = ea + eb - 127 + (sh - 23);
    if (!rm && ((rem > half) || ((rem == half) && q[0]))) q++;
    if (q == (longint'(1) << 24)) begin
      q = q >> 1;
      e++;
    end
    if (e >= 255) return {4'b0101, (rm ? {s, 31'h7F7F_FFFF} : {s, 8'hFF, 23'h0})};
    if (e <= 0) return {4'b0011, s, 31'h0};
    return {3'b000, (rem != 0), s, e[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [31:0] v;
    int k;
    v = $urandom;
    k = $urandom_range(19);
    if (k == 0) begin
      v[30:23] = 8'hFF;
      if ($urandom_range(1) == 0) v[22:0] = '0;
    end else if (k == 1) v[30:23] = 8'h00;
    else if (k == 2) v[30:23] = 8'($urandom_range(254, 190));
    else if (k == 3) v[30:23] = 8'($urandom_range(60, 1));
    else v[30:23] = 8'($urandom_range(160, 96));
    return v;
  endfunction

  task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic rm, input logic [31:0] er, input logic [3:0] ef);
    int n;
    @(negedge clk);
    io.in_valid = 1'b1;
    io.a = a;
    io.b = b;
    io.rnd_mode = rm;
    io.out_ready = 1'b1;
    #1 chk({tag, "_in_ready"}, io.in_ready, 1);
    @(negedge clk);
    io.in_valid = 1'b0;
    n = 1;
    while (!io.out_valid && n < 12) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, n, 3);
    chk({tag, "_result"}, io.result, er);
    chk({tag, "_flags"}, io.flags, ef);
  endtask

  task automatic stream(input string tag, input int n, input int p_in, input int p_out, input int stall);
    logic [35:0] exp_q[$];
    logic [35:0] want, hold_val;
    logic [31:0] pa, pb;
    logic pm;
    bit pending, hold_v;
    int sent, got, cyc;
    pa = '0; pb = '0; pm = 1'b0;
    pending = 0; hold_v = 0; hold_val = '0;
    sent = 0; got = 0; cyc = 0;
    while (got < n && cyc < 4000) begin
      @(negedge clk);
      if (!pending && sent < n && $urandom_range(99) < p_in) begin
        pa = rnd_op();
        pb = rnd_op();
        pm = 1'($urandom_range(1));
        pending = 1;
      end
      io.in_valid = pending;
      io.a = pa;
      io.b = pb;
      io.rnd_mode = pm;
      io.out_ready = (cyc >= stall) && ($urandom_range(99) < p_out);
      #1;
      if (stall > 0 && cyc == stall - 1) begin
        chk({tag, "_in_ready_full"}, io.in_ready, 0);
        chk({tag, "_accepted_when_full"}, sent, 3);
      end
      if (hold_v) begin
        chk({tag, "_hold_valid"}, io.out_valid, 1);
        chk({tag, "_hold_data"}, {io.flags, io.result}, hold_val);
      end
      if (io.out_valid && io.out_ready) begin
        chk({tag, "_expected_pending"}, exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          want = exp_q.pop_front();
          chk({tag, "_result"}, io.result, want[31:0]);
          chk({tag, "_flags"}, io.flags, want[35:32]);
        end
        got++;
      end
      hold_v   = io.out_valid && !io.out_ready;
      hold_val = {io.flags, io.result};
      if (io.in_valid && io.in_ready) begin
        exp_q.push_back(ref_mul(pa, pb, pm));
        sent++;
        pending = 0;
      end
      cyc++;
    end
    chk({tag, "_all_received"}, got, n);
    @(negedge clk);
    io.in_valid = 1'b0;
    io.out_ready = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    io.in_valid = 1'b0; io.a = '0; io.b = '0; io.rnd_mode = 1'b0; io.out_ready = 1'b0;
    io64.in_valid = 1'b0; io64.a = '0; io64.b = '0; io64.rnd_mode = 1'b0; io64.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_out_valid", io.out_valid, 0);
    chk("reset_result", io.result, 0);
    chk("reset_flags", io.flags, 0);
    chk("reset_in_ready", io.in_ready, 0);
    chk("reset_out_valid_x64", io64.out_valid, 0);
    #2 rst_n = 1'b1;
    #1 chk("release_in_ready_low", io.in_ready, 0);
    @(negedge clk);
    chk("release_in_ready_high", io.in_ready, 1);

    directed("t1_3x2p5", 32'h4040_0000, 32'h4020_0000, 1'b0, 32'h40F0_0000, 4'b0000);
    directed("t2_zero_inf", 32'h0000_0000, 32'h7F80_0000, 1'b0, 32'h7FC0_0000, 4'b1000);
    directed("t2_neginf", 32'hFF80_0000, 32'h4000_0000, 1'b0, 32'hFF80_0000, 4'b0000);
    directed("t2_snan", 32'h7F80_0001, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, 4'b1000);
    directed("t3_ovf_rne", 32'h7F00_0000, 32'h4000_0000, 1'b0, 32'h7F80_0000, 4'b0101);
    directed("t3_ovf_rtz", 32'h7F00_0000, 32'h4000_0000, 1'b1, 32'h7F7F_FFFF, 4'b0101);
    directed("t4_inexact", 32'h3F80_0001, 32'h3F80_0001, 1'b0, 32'h3F80_0002, 4'b0001);
    directed("t4_unf", 32'h0080_0000, 32'h3F00_0000, 1'b0, 32'h0000_0000, 4'b0011);
    directed("t4_daz", 32'h0000_0001, 32'hC000_0000, 1'b0, 32'h8000_0000, 4'b0000);

    stream("bp", 6, 100, 100, 8);
    stream("rand", 300, 70, 70, 0);

    @(negedge clk);
    io.out_ready = 1'b0;
    io.in_valid = 1'b1; io.a = 32'h4040_0000; io.b = 32'h4020_0000; io.rnd_mode = 1'b0;
    @(negedge clk);
    io.a = 32'h3F80_0001; io.b = 32'h3F80_0001;
    @(negedge clk);
    io.in_valid = 1'b0;
    @(negedge clk);
    chk("rst_pre_out_valid", io.out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_out_valid", io.out_valid, 0);
    chk("rst_async_result", io.result, 0);
    chk("rst_async_flags", io.flags, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 chk("rst_release_in_ready_low", io.in_ready, 0);
    @(negedge clk);
    chk("rst_release_in_ready_high", io.in_ready, 1);
    io.out_ready = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (io.out_valid) seen++;
    end
    chk("rst_no_stale_beat", seen, 0);

    @(negedge clk);
    io64.in_valid = 1'b1;
    io64.a = 64'h4008_0000_0000_0000;
    io64.b = 64'h4004_0000_0000_0000;
    io64.rnd_mode = 1'b0;
    #1 chk("x64_in_ready", io64.in_ready, 1);
    @(negedge clk);
    io64.in_valid = 1'b0;
    lat = 1;
    while (!io64.out_valid && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    chk("x64_latency", lat, 3);
    chk("x64_result", io64.result, 64'h401E_0000_0000_0000);
    chk("x64_flags", io64.flags, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
